seq_alu: RTL and testbench

- Parametrised, registered ALU and the successor to the current combinational 16-bit datapath ALU.
- Adds a carry-in, true signed overflow, multi-bit shifts/rotates and an iterative multiply.
- Uses a Start/Ready/Done handshake so the control unit can stall on multi-cycle operations.
- Sits between the register-file read ports and the writeback mux in the CPU datapath.

---
 rtl/seq_alu.sv | 216 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered ALU with carry-in, signed overflow, iterative shifts/rotates and an
// optional shift-add multiplier (built only when ALU_MUL_EN is defined).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | Ready=1, waiting for Start; single-cycle ops resolve here
// SHIFT  | one 1-bit shift/rotate step per cycle, counter counts down
// MUL    | one shift-add iteration per cycle, WIDTH iterations total
// DONE   | Done=1 for one cycle, Result/Flags valid, then back to IDLE
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Start,
    input  logic [3:0]       AluOp,
    input  logic [WIDTH-1:0] Op1,
    input  logic [WIDTH-1:0] Op2,
    input  logic             CarryIn,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       Flags
);

    localparam int CW  = $clog2(WIDTH + 1);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_MOV = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_ADC = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_SBC = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;
    localparam logic [3:0] OP_LSL = 4'd9;
    localparam logic [3:0] OP_LSR = 4'd10;
    localparam logic [3:0] OP_ASR = 4'd11;
    localparam logic [3:0] OP_ROR = 4'd12;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd13;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MUL,
        ST_DONE
    } state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] sh_val, sh_val_d;
    logic [3:0]       sh_op, sh_op_d;
    logic [WIDTH-1:0] res_d;
    logic [3:0]       flg_d;

    logic [WIDTH:0]   add_w, sub_w;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v;
    logic [WIDTH-1:0] step_val;
    logic             step_c;
    logic [SHW-1:0]   amt;
    logic             is_shift;

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c,
                                            input logic v);
        return {r == '0, r[MSB], c, v};
    endfunction

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mul_acc, mul_acc_d, mul_next;
    logic [WIDTH-1:0]   mul_cand, mul_cand_d;
    logic [WIDTH:0]     mul_sum;

    // Right-shifting accumulator: multiplier sits in the low half and is consumed LSB first.
    assign mul_sum  = {1'b0, mul_acc[2*WIDTH-1:WIDTH]} + (mul_acc[0] ? {1'b0, mul_cand} : '0);
    assign mul_next = {mul_sum, mul_acc[WIDTH-1:1]};
`endif

    assign amt      = Op2[SHW-1:0];
    assign is_shift = (AluOp >= OP_LSL) && (AluOp <= OP_ROR);
    assign Ready    = (state == ST_IDLE);
    assign Done     = (state == ST_DONE);

    always_comb begin
        add_w = {1'b0, Op1} + {1'b0, Op2} + {{WIDTH{1'b0}}, (AluOp == OP_ADC) & CarryIn};
        sub_w = {1'b0, Op1} - {1'b0, Op2} - {{WIDTH{1'b0}}, (AluOp == OP_SBC) & CarryIn};
    end

    // Shift ops only reach this path with a zero amount, so they pass Op1 through.
    always_comb begin
        sc_res = Op1;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (AluOp)
            OP_ADD, OP_ADC: begin
                sc_res = add_w[MSB:0];
                sc_c   = add_w[WIDTH];
                sc_v   = (Op1[MSB] == Op2[MSB]) && (add_w[MSB] != Op1[MSB]);
            end
            OP_SUB, OP_SBC: begin
                sc_res = sub_w[MSB:0];
                sc_c   = sub_w[WIDTH];
                sc_v   = (Op1[MSB] != Op2[MSB]) && (sub_w[MSB] != Op1[MSB]);
            end
            OP_AND:  sc_res = Op1 & Op2;
            OP_OR:   sc_res = Op1 | Op2;
            OP_XOR:  sc_res = Op1 ^ Op2;
            OP_NOT:  sc_res = ~Op1;
            default: sc_res = Op1;
        endcase
    end

    always_comb begin
        step_val = {sh_val[0], sh_val[MSB:1]};
        step_c   = sh_val[0];
        case (sh_op)
            OP_LSL: begin
                step_val = {sh_val[MSB-1:0], 1'b0};
                step_c   = sh_val[MSB];
            end
            OP_LSR:  step_val = {1'b0, sh_val[MSB:1]};
            OP_ASR:  step_val = {sh_val[MSB], sh_val[MSB:1]};
            default: step_val = {sh_val[0], sh_val[MSB:1]};
        endcase
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        sh_val_d = sh_val;
        sh_op_d  = sh_op;
        res_d    = Result;
        flg_d    = Flags;
`ifdef ALU_MUL_EN
        mul_acc_d  = mul_acc;
        mul_cand_d = mul_cand;
`endif
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    if (is_shift && (amt != '0)) begin
                        state_d  = ST_SHIFT;
                        cnt_d    = CW'(amt);
                        sh_val_d = Op1;
                        sh_op_d  = AluOp;
`ifdef ALU_MUL_EN
                    end else if (AluOp == OP_MUL) begin
                        state_d    = ST_MUL;
                        cnt_d      = CW'(WIDTH);
                        mul_acc_d  = {{WIDTH{1'b0}}, Op2};
                        mul_cand_d = Op1;
`endif
                    end else begin
                        state_d = ST_DONE;
                        res_d   = sc_res;
                        flg_d   = mk_flags(sc_res, sc_c, sc_v);
                    end
                end
            end
            ST_SHIFT: begin
                sh_val_d = step_val;
                cnt_d    = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_d = ST_DONE;
                    res_d   = step_val;
                    flg_d   = mk_flags(step_val, step_c, 1'b0);
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                mul_acc_d = mul_next;
                cnt_d     = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_d = ST_DONE;
                    res_d   = mul_next[MSB:0];
                    flg_d   = mk_flags(mul_next[MSB:0], |mul_next[2*WIDTH-1:WIDTH], 1'b0);
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sh_val   <= '0;
            sh_op    <= OP_MOV;
            Result   <= '0;
            Flags    <= '0;
`ifdef ALU_MUL_EN
            mul_acc  <= '0;
            mul_cand <= '0;
`endif
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            sh_val   <= sh_val_d;
            sh_op    <= sh_op_d;
            Result   <= res_d;
            Flags    <= flg_d;
`ifdef ALU_MUL_EN
            mul_acc  <= mul_acc_d;
            mul_cand <= mul_cand_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=16): directed vectors plus random ops
// compared against an arithmetic reference model; honours ALU_MUL_EN.
module tb_seq_alu;

    localparam int W = 16;

    logic         Clock = 1'b0;
    logic         nReset;
    logic         Start;
    logic [3:0]   AluOp;
    logic [W-1:0] Op1;
    logic [W-1:0] Op2;
    logic         CarryIn;
    logic         Ready;
    logic         Done;
    logic [W-1:0] Result;
    logic [3:0]   Flags;

    int npass  = 0;
    int nfail  = 0;
    int ntotal = 0;

    always #5 Clock = ~Clock;

    seq_alu #(.WIDTH(W)) dut (
        .Clock(Clock),
        .nReset(nReset),
        .Start(Start),
        .AluOp(AluOp),
        .Op1(Op1),
        .Op2(Op2),
        .CarryIn(CarryIn),
        .Ready(Ready),
        .Done(Done),
        .Result(Result),
        .Flags(Flags)
    );

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        int          lat;
    } exp_t;

    function automatic exp_t mk(input logic [15:0] res, input logic [3:0] flg, input int lat);
        exp_t e;
        e.res = res;
        e.flg = flg;
        e.lat = lat;
        return e;
    endfunction

    // Reference: plain integer arithmetic on the operation definitions.
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic cin);
        longint ua, ub, sa, sb, r, sr, ci;
        int     k;
        bit     c, v;
        int     lat;
        exp_t   e;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = a[15] ? ua - 65536 : ua;
        sb  = b[15] ? ub - 65536 : ub;
        k   = int'(b[3:0]);
        c   = 1'b0;
        v   = 1'b0;
        lat = 1;
        r   = ua;
        ci  = 0;
        case (op)
            4'd1, 4'd2: begin
                ci = (op == 4'd2) ? longint'(cin) : 0;
                r  = ua + ub + ci;
                c  = (r > 65535);
                sr = sa + sb + ci;
                v  = (sr > 32767) || (sr < -32768);
            end
            4'd3, 4'd4: begin
                ci = (op == 4'd4) ? longint'(cin) : 0;
                r  = ua - ub - ci;
                c  = (ua < ub + ci);
                sr = sa - sb - ci;
                v  = (sr > 32767) || (sr < -32768);
            end
            4'd5: r = ua & ub;
            4'd6: r = ua | ub;
            4'd7: r = ua ^ ub;
            4'd8: r = ~ua;
            4'd9: begin
                r   = ua << k;
                c   = (k != 0) && (((ua >> (16 - k)) & 1) != 0);
                lat = k + 1;
            end
            4'd10: begin
                r   = ua >> k;
                c   = (k != 0) && (((ua >> (k - 1)) & 1) != 0);
                lat = k + 1;
            end
            4'd11: begin
                r   = sa >>> k;
                c   = (k != 0) && (((ua >> (k - 1)) & 1) != 0);
                lat = k + 1;
            end
            4'd12: begin
                r   = (ua >> k) | (ua << (16 - k));
                c   = (k != 0) && (((r >> 15) & 1) != 0);
                lat = k + 1;
            end
`ifdef ALU_MUL_EN
            4'd13: begin
                r   = ua * ub;
                c   = ((r >> 16) != 0);
                lat = 17;
            end
`endif
            default: r = ua;
        endcase
        e.res = r[15:0];
        e.flg = {e.res == 16'h0, e.res[15], c, v};
        e.lat = lat;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic cin, input bit poke,
                          input exp_t e);
        int n;
        @(negedge Clock);
        AluOp   = op;
        Op1     = a;
        Op2     = b;
        CarryIn = cin;
        Start   = 1'b1;
        @(negedge Clock);
        n       = 1;
        Start   = 1'b0;
        AluOp   = 4'($urandom);
        Op1     = 16'($urandom);
        Op2     = 16'($urandom);
        CarryIn = 1'($urandom);
        while (Done !== 1'b1 && n < 64) begin
            if (poke) begin
                Start   = 1'b1;
                AluOp   = 4'($urandom);
                Op1     = 16'($urandom);
                Op2     = 16'($urandom);
                CarryIn = 1'($urandom);
            end
            @(negedge Clock);
            n++;
        end
        Start = 1'b0;
        chk({tag, "_lat"}, 32'(n), 32'(e.lat));
        chk({tag, "_res"}, 32'(Result), 32'(e.res));
        chk({tag, "_flags"}, 32'(Flags), 32'(e.flg));
        @(negedge Clock);
        chk({tag, "_pulse"}, {30'd0, Done, Ready}, 32'd1);
    endtask

    task automatic reset_mid(input string tag, input logic [3:0] op, input logic [15:0] a,
                             input logic [15:0] b);
        bit seen;
        @(negedge Clock);
        AluOp = op;
        Op1   = a;
        Op2   = b;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (3) @(negedge Clock);
        nReset = 1'b0;
        #1;
        chk({tag, "_ready"}, 32'(Ready), 32'd1);
        chk({tag, "_done"}, 32'(Done), 32'd0);
        chk({tag, "_res"}, 32'(Result), 32'd0);
        chk({tag, "_flags"}, 32'(Flags), 32'd0);
        @(negedge Clock);
        @(negedge Clock);
        nReset = 1'b1;
        seen   = 1'b0;
        repeat (24) begin
            @(negedge Clock);
            if (Done === 1'b1) seen = 1'b1;
        end
        chk({tag, "_no_done"}, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] a, b;
        logic        cin;
        bit          poke;

        nReset  = 1'b0;
        Start   = 1'b0;
        AluOp   = 4'd0;
        Op1     = 16'h0;
        Op2     = 16'h0;
        CarryIn = 1'b0;
        repeat (2) @(negedge Clock);
        chk("rst_ready", 32'(Ready), 32'd1);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_res", 32'(Result), 32'd0);
        chk("rst_flags", 32'(Flags), 32'd0);
        nReset = 1'b1;

        run_op("add_ovf", 4'd1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 4'b0101, 1));
        run_op("add_wrap", 4'd1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 4'b1010, 1));
        run_op("sbc", 4'd4, 16'd5, 16'd3, 1'b1, 1'b0, mk(16'h0001, 4'b0000, 1));
        run_op("asr4", 4'd11, 16'h8010, 16'd4, 1'b0, 1'b1, mk(16'hF801, 4'b0100, 5));
        run_op("ror0", 4'd12, 16'h0001, 16'd0, 1'b0, 1'b0, mk(16'h0001, 4'b0000, 1));
        run_op("ror1", 4'd12, 16'h0001, 16'd1, 1'b0, 1'b1, mk(16'h8000, 4'b0110, 2));
`ifdef ALU_MUL_EN
        run_op("mul", 4'd13, 16'h0100, 16'h0100, 1'b0, 1'b1, mk(16'h0000, 4'b1010, 17));
`else
        run_op("mul", 4'd13, 16'h0100, 16'h0100, 1'b0, 1'b0, mk(16'h0100, 4'b0000, 1));
`endif

        reset_mid("rst_shift", 4'd12, 16'h1234, 16'd12);
`ifdef ALU_MUL_EN
        run_op("pre_mul", 4'd8, 16'h00F0, 16'h0000, 1'b0, 1'b0, mk(16'hFF0F, 4'b0100, 1));
        reset_mid("rst_mul", 4'd13, 16'h1234, 16'h5678);
`endif

        for (int i = 0; i < 40; i++) begin
            op   = 4'($urandom_range(0, 15));
            a    = 16'($urandom);
            b    = 16'($urandom);
            cin  = 1'($urandom);
            poke = 1'($urandom);
            run_op("rnd", op, a, b, cin, poke, model(op, a, b, cin));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
